// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MIPS memory stage and data memory.
// The stage is the master: it drives the request fields and receives read data and the ack.
interface mem_stage_if;
   logic        dm_req;
   logic        dm_we;
   logic [3:0]  dm_be;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_ack;

   modport master (
      output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      input  dm_rdata, dm_ack
   );

   modport slave (
      input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
      output dm_rdata, dm_ack
   );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: passes ALU results through and runs loads/stores as req/ack
// transactions, stalling the pipeline until the extended load data can be written back.
module mem_stage #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int REG_DATA_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
   input  logic [REG_DATA_WIDTH-1:0] w_reg_data_in,
   input  logic                      w_reg_en_in,
   input  logic [3:0]                mem_op_in,
   input  logic [31:0]               mem_addr_in,
   input  logic [31:0]               mem_wdata_in,
   output logic [REG_ADDR_WIDTH-1:0] w_reg_addr_out,
   output logic [REG_DATA_WIDTH-1:0] w_reg_data_out,
   output logic                      w_reg_en_out,
   output logic                      stall_req,
   output logic                      misalign,
   mem_stage_if.master               dm
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q, op_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] rdata_q, rdata_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;

   logic        in_load, in_store, in_byte, in_half, in_word, in_mis, in_go;
   logic        held_load;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;
   logic [31:0] load_ext;

   assign in_load   = (mem_op_in >= OP_LB) && (mem_op_in <= OP_LW);
   assign in_store  = (mem_op_in >= OP_SB) && (mem_op_in <= OP_SW);
   assign in_byte   = (mem_op_in == OP_LB) || (mem_op_in == OP_LBU) || (mem_op_in == OP_SB);
   assign in_half   = (mem_op_in == OP_LH) || (mem_op_in == OP_LHU) || (mem_op_in == OP_SH);
   assign in_word   = (mem_op_in == OP_LW) || (mem_op_in == OP_SW);
   assign in_mis    = (in_half && mem_addr_in[0]) || (in_word && (mem_addr_in[1:0] != 2'b00));
   assign in_go     = (in_load || in_store) && !in_mis;
   assign held_load = (op_q >= OP_LB) && (op_q <= OP_LW);

   always_comb begin
      be_new = 4'b1111;
      if (in_byte) begin
         be_new = 4'b0001 << mem_addr_in[1:0];
      end else if (in_half) begin
         be_new = mem_addr_in[1] ? 4'b1100 : 4'b0011;
      end
   end

   // Each enabled lane takes the store byte that lands on it; disabled lanes stay zero.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
         assign wdata_new[gi*8 +: 8] = !be_new[gi] ? 8'h00 :
                                       in_byte     ? mem_wdata_in[7:0] :
                                       in_half     ? mem_wdata_in[(gi%2)*8 +: 8] :
                                                     mem_wdata_in[gi*8 +: 8];
      end
   endgenerate

   always_comb begin
      sel_byte = dm.dm_rdata[lane_q*8 +: 8];
      sel_half = lane_q[1] ? dm.dm_rdata[31:16] : dm.dm_rdata[15:0];
      case (op_q)
         OP_LB:   load_ext = {{24{sel_byte[7]}}, sel_byte};
         OP_LBU:  load_ext = {24'h0, sel_byte};
         OP_LH:   load_ext = {{16{sel_half[15]}}, sel_half};
         OP_LHU:  load_ext = {16'h0, sel_half};
         default: load_ext = dm.dm_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      lane_d  = lane_q;
      rdata_d = rdata_q;
      req_d   = req_q;
      we_d    = we_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (in_go) begin
               state_d = S_BUSY;
               op_d    = mem_op_in;
               lane_d  = mem_addr_in[1:0];
               req_d   = 1'b1;
               we_d    = in_store;
               be_d    = be_new;
               addr_d  = {mem_addr_in[31:2], 2'b00};
               wdata_d = in_store ? wdata_new : 32'h0;
            end
         end
         S_BUSY: begin
            if (dm.dm_ack) begin
               state_d = S_DONE;
               req_d   = 1'b0;
               if (held_load) begin
                  rdata_d = load_ext;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are forced low for the whole time reset is asserted, not only at the edge.
   always_comb begin
      w_reg_addr_out = '0;
      w_reg_data_out = '0;
      w_reg_en_out   = 1'b0;
      stall_req      = 1'b0;
      misalign       = 1'b0;
      if (rst_n) begin
         w_reg_addr_out = w_reg_addr_in;
         w_reg_data_out = w_reg_data_in;
         case (state_q)
            S_IDLE: begin
               if (in_load || in_store) begin
                  misalign  = in_mis;
                  stall_req = in_go;
               end else begin
                  w_reg_en_out = w_reg_en_in;
               end
            end
            S_BUSY: stall_req = 1'b1;
            S_DONE: begin
               if (held_load) begin
                  w_reg_data_out = rdata_q;
                  w_reg_en_out   = w_reg_en_in;
               end
            end
            default: stall_req = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= 4'h0;
         lane_q  <= 2'b00;
         rdata_q <= 32'h0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         be_q    <= 4'h0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         lane_q  <= lane_d;
         rdata_q <= rdata_d;
         req_q   <= req_d;
         we_q    <= we_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign dm.dm_req   = req_q;
   assign dm.dm_we    = we_q;
   assign dm.dm_be    = be_q;
   assign dm.dm_addr  = addr_q;
   assign dm.dm_wdata = wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: a transaction-level model predicts each cycle's outputs
// from the load/store rules and a scripted memory responder supplies ack and read data.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  w_reg_addr_in;
   logic [31:0] w_reg_data_in;
   logic        w_reg_en_in;
   logic [3:0]  mem_op_in;
   logic [31:0] mem_addr_in;
   logic [31:0] mem_wdata_in;
   logic [4:0]  w_reg_addr_out;
   logic [31:0] w_reg_data_out;
   logic        w_reg_en_out;
   logic        stall_req;
   logic        misalign;

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   mem_stage_if dm_bus ();

   always #5 clk = ~clk;

   mem_stage #(
      .REG_ADDR_WIDTH(5),
      .REG_DATA_WIDTH(32)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .w_reg_addr_in  (w_reg_addr_in),
      .w_reg_data_in  (w_reg_data_in),
      .w_reg_en_in    (w_reg_en_in),
      .mem_op_in      (mem_op_in),
      .mem_addr_in    (mem_addr_in),
      .mem_wdata_in   (mem_wdata_in),
      .w_reg_addr_out (w_reg_addr_out),
      .w_reg_data_out (w_reg_data_out),
      .w_reg_en_out   (w_reg_en_out),
      .stall_req      (stall_req),
      .misalign       (misalign),
      .dm             (dm_bus.master)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // ---- reference model: plain arithmetic over access size and byte lane ----
   function automatic int op_size(input int op);
      case (op)
         1, 2, 6: return 1;
         3, 4, 7: return 2;
         5, 8:    return 4;
         default: return 0;
      endcase
   endfunction

   function automatic bit is_load(input int op);
      return (op >= 1) && (op <= 5);
   endfunction

   function automatic bit is_store(input int op);
      return (op >= 6) && (op <= 8);
   endfunction

   function automatic bit model_mis(input int op, input logic [31:0] addr);
      int sz = op_size(op);
      return (sz > 1) && ((int'(addr & 32'd3) % sz) != 0);
   endfunction

   function automatic logic [31:0] model_be(input int op, input logic [31:0] addr);
      longint m = ((longint'(1) << op_size(op)) - 1) << int'(addr & 32'd3);
      return 32'(m);
   endfunction

   function automatic logic [31:0] model_wdata(input int op, input logic [31:0] addr, input logic [31:0] wd);
      longint mask = (longint'(1) << (8 * op_size(op))) - 1;
      longint v    = (longint'({32'h0, wd}) & mask) << (8 * int'(addr & 32'd3));
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_load(input int op, input logic [31:0] addr, input logic [31:0] rd);
      longint v = longint'({32'h0, rd}) >> (8 * int'(addr & 32'd3));
      case (op)
         1: begin v = v & 255;   if (v >= 128)   v = v - 256;   end
         2: v = v & 255;
         3: begin v = v & 65535; if (v >= 32768) v = v - 65536; end
         4: v = v & 65535;
         default: v = longint'({32'h0, rd});
      endcase
      return 32'(v);
   endfunction

   // One instruction through the stage; n_busy = number of cycles before the memory acks.
   task automatic run_op(input int op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] alu, input logic en, input logic [4:0] ra,
                         input logic [31:0] rd, input int n_busy);
      int stall_cnt = 0;
      bit mem = is_load(op) || is_store(op);
      @(negedge clk);
      mem_op_in     = 4'(op);
      mem_addr_in   = addr;
      mem_wdata_in  = wd;
      w_reg_data_in = alu;
      w_reg_en_in   = en;
      w_reg_addr_in = ra;
      dm_bus.dm_ack = mem ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      txn++;
      if (!mem) begin
         check_val("pass_addr", 32'(w_reg_addr_out), 32'(ra));
         check_val("pass_data", w_reg_data_out, alu);
         check_val("pass_en", 32'(w_reg_en_out), 32'(en));
         check_val("pass_stall", 32'(stall_req), 32'd0);
         check_val("pass_mis", 32'(misalign), 32'd0);
         check_val("pass_req", 32'(dm_bus.dm_req), 32'd0);
         $display("txn %0d op=%0d passthrough data=0x%08h en=%0d", txn, op, alu, en);
         return;
      end
      if (model_mis(op, addr)) begin
         check_val("mis_flag", 32'(misalign), 32'd1);
         check_val("mis_stall", 32'(stall_req), 32'd0);
         check_val("mis_en", 32'(w_reg_en_out), 32'd0);
         @(negedge clk);
         mem_op_in = 4'd0;
         #1;
         check_val("mis_no_req", 32'(dm_bus.dm_req), 32'd0);
         $display("txn %0d op=%0d addr=0x%08h misaligned", txn, op, addr);
         return;
      end
      check_val("idle_mis", 32'(misalign), 32'd0);
      check_val("idle_en", 32'(w_reg_en_out), 32'd0);
      check_val("idle_req", 32'(dm_bus.dm_req), 32'd0);
      if (stall_req) stall_cnt++;
      for (int b = 1; b <= n_busy; b++) begin
         @(negedge clk);
         dm_bus.dm_ack   = (b == n_busy);
         dm_bus.dm_rdata = (b == n_busy) ? rd : $urandom;
         #1;
         if (stall_req) stall_cnt++;
         check_val("busy_req", 32'(dm_bus.dm_req), 32'd1);
         check_val("busy_en", 32'(w_reg_en_out), 32'd0);
         check_val("busy_we", 32'(dm_bus.dm_we), 32'(is_store(op)));
         check_val("busy_be", 32'(dm_bus.dm_be), model_be(op, addr));
         check_val("busy_addr", dm_bus.dm_addr, addr & 32'hFFFF_FFFC);
         if (is_store(op)) check_val("busy_wdata", dm_bus.dm_wdata, model_wdata(op, addr, wd));
      end
      @(negedge clk);
      dm_bus.dm_ack   = 1'b0;
      dm_bus.dm_rdata = $urandom;
      #1;
      if (stall_req) stall_cnt++;
      check_val("done_req", 32'(dm_bus.dm_req), 32'd0);
      check_val("done_addr", 32'(w_reg_addr_out), 32'(ra));
      check_val("done_en", 32'(w_reg_en_out), is_load(op) ? 32'(en) : 32'd0);
      if (is_load(op)) check_val("done_data", w_reg_data_out, model_load(op, addr, rd));
      check_val("stall_len", 32'(stall_cnt), 32'(1 + n_busy));
      $display("txn %0d op=%0d addr=0x%08h wd=0x%08h rd=0x%08h busy=%0d out=0x%08h en=%0d",
               txn, op, addr, wd, rd, n_busy, w_reg_data_out, w_reg_en_out);
   endtask

   initial begin
      w_reg_addr_in   = 5'd9;
      w_reg_data_in   = 32'hFFFF_0000;
      w_reg_en_in     = 1'b1;
      mem_op_in       = 4'd5;
      mem_addr_in     = 32'h0;
      mem_wdata_in    = 32'h0;
      dm_bus.dm_ack   = 1'b0;
      dm_bus.dm_rdata = 32'h0;
      #1;
      check_val("rst_addr", 32'(w_reg_addr_out), 32'd0);
      check_val("rst_data", w_reg_data_out, 32'd0);
      check_val("rst_en", 32'(w_reg_en_out), 32'd0);
      check_val("rst_stall", 32'(stall_req), 32'd0);
      check_val("rst_req", 32'(dm_bus.dm_req), 32'd0);
      @(negedge clk);
      mem_op_in = 4'd0;
      @(negedge clk);
      rst_n = 1'b1;

      run_op(0, 32'h3, 32'h0, 32'h1234_5678, 1'b1, 5'd3, 32'h0, 1);
      run_op(1, 32'h1003, 32'h0, 32'h0, 1'b1, 5'd4, 32'h8000_0000, 1);
      run_op(2, 32'h1003, 32'h0, 32'h0, 1'b1, 5'd4, 32'h8000_0000, 1);
      run_op(7, 32'h102, 32'h0000_ABCD, 32'h0, 1'b1, 5'd0, 32'h0, 2);
      run_op(5, 32'h200, 32'h0, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF, 3);
      run_op(5, 32'h202, 32'h0, 32'h0, 1'b1, 5'd7, 32'h0, 1);

      // reset abandoned in the middle of a transaction
      @(negedge clk);
      mem_op_in   = 4'd5;
      mem_addr_in = 32'h300;
      @(negedge clk);
      #1;
      check_val("mid_busy_req", 32'(dm_bus.dm_req), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_req", 32'(dm_bus.dm_req), 32'd0);
      check_val("mid_rst_stall", 32'(stall_req), 32'd0);
      check_val("mid_rst_en", 32'(w_reg_en_out), 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      mem_op_in = 4'd0;
      run_op(0, 32'h0, 32'h0, 32'h0000_0055, 1'b1, 5'd7, 32'h0, 1);
      dm_bus.dm_ack = 1'b1;
      #1;
      check_val("late_ack_stall", 32'(stall_req), 32'd0);
      run_op(15, 32'h0, 32'h0, 32'h0000_0066, 1'b1, 5'd8, 32'h0, 1);
      run_op(5, 32'h202, 32'h0, 32'h0, 1'b1, 5'd7, 32'h0, 1);
      $display("txn %0d reset during busy, late ack ignored", txn);

      for (int i = 0; i < 60; i++) begin
         int          op  = $urandom_range(0, 15);
         logic [31:0] a   = $urandom;
         int          sz  = op_size(op);
         if ((sz > 1) && ($urandom_range(0, 3) != 0)) a = a & ~32'(sz - 1);
         run_op(op, a, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom, $urandom_range(1, 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
